demux_1_4_8_bit_reg: RTL

DEMUX_1_4_8_BIT_REG -- requirements
Module: demux_1_4_8_bit_reg

---
 rtl/demux_1_4_8_bit_reg_pkg.sv | 15 +
 rtl/demux_chan_reg.sv | 57 +++++
 rtl/demux_1_4_8_bit_reg.sv | 71 +++++++
 3 files changed

// File: rtl/demux_1_4_8_bit_reg_pkg.sv
// Shared constants and types for the 1-to-4 registered demux.
// Channel count, select width, counter width, default data width, channel state.
package demux_1_4_8_bit_reg_pkg;

  localparam int NUM_CH     = 4;
  localparam int SEL_W      = 2;
  localparam int CNT_W      = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic {
    CH_EMPTY = 1'b0,
    CH_FULL  = 1'b1
  } chan_state_t;

endpackage

// File: rtl/demux_chan_reg.sv
// One output channel: DATA_W holding register with a valid flag.
// Ports: i_clk, i_rst_n, i_load, i_ready, i_code -> o_code, o_valid.
module demux_chan_reg
  import demux_1_4_8_bit_reg_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic              i_ready,
  input  logic [DATA_W-1:0] i_code,
  output logic [DATA_W-1:0] o_code,
  output logic              o_valid
);

  chan_state_t       r_state;
  chan_state_t       w_state_nxt;
  logic [DATA_W-1:0] r_code;
  logic              w_consume;

  always_comb begin
    w_state_nxt = r_state;
    w_consume   = (r_state == CH_FULL) & i_ready;
    unique case (r_state)
      CH_EMPTY: begin
        if (i_load) w_state_nxt = CH_FULL;
      end
      CH_FULL: begin
        // a load in the same cycle as a consume keeps the slot full
        if (w_consume & ~i_load) w_state_nxt = CH_EMPTY;
      end
      default: w_state_nxt = CH_EMPTY;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= CH_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // code is only overwritten on load; it is kept after consumption
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_code <= '0;
    end else if (i_load) begin
      r_code <= i_code;
    end
  end

  assign o_code  = r_code;
  assign o_valid = (r_state == CH_FULL);

endmodule

// File: rtl/demux_1_4_8_bit_reg.sv
// 1-to-4 registered demux with valid/ready on input and each output.
// Ports: i_en/i_valid/i_code/i_sel_code in, o_ready; o_code_0..3/o_valid out, i_ready; o_xfer_cnt.
module demux_1_4_8_bit_reg
  import demux_1_4_8_bit_reg_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_code,
  input  logic [SEL_W-1:0]  i_sel_code,
  output logic [DATA_W-1:0] o_code_0,
  output logic [DATA_W-1:0] o_code_1,
  output logic [DATA_W-1:0] o_code_2,
  output logic [DATA_W-1:0] o_code_3,
  output logic [NUM_CH-1:0] o_valid,
  input  logic [NUM_CH-1:0] i_ready,
  output logic [CNT_W-1:0]  o_xfer_cnt
);

  logic [NUM_CH-1:0] w_valid;
  logic [NUM_CH-1:0] w_load;
  logic [DATA_W-1:0] w_code [NUM_CH];
  logic              w_xfer;
  logic [CNT_W-1:0]  r_xfer_cnt;

  // selected slot can take data if empty or draining this cycle
  assign o_ready = i_en
                 & (~w_valid[i_sel_code] | i_ready[i_sel_code]);
  assign w_xfer  = i_valid & o_ready;

  always_comb begin
    w_load = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      w_load[n] = w_xfer & (i_sel_code == SEL_W'(n));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    demux_chan_reg #(
      .DATA_W (DATA_W)
    ) u_chan (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_load  (w_load[g]),
      .i_ready (i_ready[g]),
      .i_code  (i_code),
      .o_code  (w_code[g]),
      .o_valid (w_valid[g])
    );
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_xfer_cnt <= '0;
    end else if (w_xfer) begin
      r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
    end
  end

  assign o_code_0   = w_code[0];
  assign o_code_1   = w_code[1];
  assign o_code_2   = w_code[2];
  assign o_code_3   = w_code[3];
  assign o_valid    = w_valid;
  assign o_xfer_cnt = r_xfer_cnt;

endmodule
